// File: rtl/hit_pkg.sv
// Shared types and 50 MHz defaults for the whack-sensor front end.
package hit_pkg;

  localparam logic [1:0] BOX_NONE            = 2'b11;
  localparam int         DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms
  localparam int         LOCKOUT_CYCLES_DEF  = 5000000;  // 100 ms

  typedef enum logic [1:0] {IDLE, ARMED, LOCKOUT} hit_state_t;

  // Fixed priority: lowest box index wins a same-cycle collision.
  function automatic logic [1:0] lowest_box(input logic [2:0] ev);
    logic [1:0] box;
    box = BOX_NONE;
    if (ev[2]) box = 2'd2;
    if (ev[1]) box = 2'd1;
    if (ev[0]) box = 2'd0;
    return box;
  endfunction

endpackage

// File: rtl/hit_sensor_frontend_if.sv
// Sensor-side inputs and hit-event outputs of the front end.
interface hit_sensor_frontend_if #(parameter int NUM_SENSORS = 3);
  logic [NUM_SENSORS-1:0] sensor_raw;
  logic                   arm;
  logic                   hit_valid;
  logic [1:0]             hit_box;
  logic                   hit_multi;
  logic [NUM_SENSORS-1:0] sensor_level;
  logic [7:0]             dropped_count;

  modport master (input sensor_raw, arm,
                  output hit_valid, hit_box, hit_multi, sensor_level, dropped_count);
  modport slave  (output sensor_raw, arm,
                  input hit_valid, hit_box, hit_multi, sensor_level, dropped_count);
endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-FF synchroniser, stable-count debounce, rising-edge detect.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          deb_q, deb_d;
  logic          deb_dly_q, deb_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle that agrees with the accepted level restarts the count.
  always_comb begin
    meta_d    = raw;
    sync_d    = meta_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level = deb_q;
  assign rise  = deb_q & ~deb_dly_q;

endmodule

// File: rtl/hit_sensor_frontend.sv
// Debounced hit events, arbitration and arm FSM feeding the game datapath.
// Define HIT_LOCKOUT_EN to build the post-hit lockout window and drop counter.
module hit_sensor_frontend
  import hit_pkg::*;
#(
  parameter int NUM_SENSORS     = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input logic                    CLOCK_50,
  input logic                    reset,
  hit_sensor_frontend_if.master  bus
);

  logic [NUM_SENSORS-1:0] raw_w, level_w, ev;
  logic [2:0]             ev3;

  assign raw_w = bus.sensor_raw;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_SENSORS-1:0] (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .raw      (raw_w),
    .level    (level_w),
    .rise     (ev)
  );

  always_comb begin
    ev3 = '0;
    ev3[NUM_SENSORS-1:0] = ev;
  end

  hit_state_t state_q, state_d;
  logic       hit_valid_q, hit_valid_d;
  logic       hit_multi_q, hit_multi_d;
  logic [1:0] hit_box_q, hit_box_d;

`ifdef HIT_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_q, lock_d;
  logic [7:0]    drop_q, drop_d;
`else
  logic unused_lockout_cfg;
  assign unused_lockout_cfg = ^32'(LOCKOUT_CYCLES);
`endif

  always_comb begin
    state_d     = state_q;
    hit_valid_d = 1'b0;
    hit_multi_d = 1'b0;
    hit_box_d   = hit_box_q;
`ifdef HIT_LOCKOUT_EN
    lock_d      = lock_q;
    drop_d      = drop_q;
`endif
    case (state_q)
      IDLE:  if (bus.arm) state_d = ARMED;
      ARMED: begin
        if (|ev) begin
          hit_valid_d = 1'b1;
          hit_box_d   = lowest_box(ev3);
          hit_multi_d = ($countones(ev) > 1);
`ifdef HIT_LOCKOUT_EN
          state_d     = LOCKOUT;
          lock_d      = LW'(LOCKOUT_CYCLES - 1);
`endif
        end
      end
`ifdef HIT_LOCKOUT_EN
      LOCKOUT: begin
        if (|ev && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (lock_q == '0) state_d = ARMED;
        else              lock_d  = lock_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Disarm wins over everything, but a hit on the same edge still reports.
    if (!bus.arm) begin
      state_d = IDLE;
`ifdef HIT_LOCKOUT_EN
      lock_d  = '0;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hit_valid_q <= 1'b0;
      hit_multi_q <= 1'b0;
      hit_box_q   <= BOX_NONE;
`ifdef HIT_LOCKOUT_EN
      lock_q      <= '0;
      drop_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hit_valid_q <= hit_valid_d;
      hit_multi_q <= hit_multi_d;
      hit_box_q   <= hit_box_d;
`ifdef HIT_LOCKOUT_EN
      lock_q      <= lock_d;
      drop_q      <= drop_d;
`endif
    end
  end

  assign bus.hit_valid    = hit_valid_q;
  assign bus.hit_box      = hit_box_q;
  assign bus.hit_multi    = hit_multi_q;
  assign bus.sensor_level = level_w;
`ifdef HIT_LOCKOUT_EN
  assign bus.dropped_count = drop_q;
`else
  assign bus.dropped_count = 8'd0;
`endif

endmodule

// File: tb/tb_hit_sensor_frontend.sv
// Bench for hit_sensor_frontend: directed timing scenarios plus random traffic vs a window-based model.
module tb_hit_sensor_frontend;
  import hit_pkg::*;

  localparam int NS   = 3;
  localparam int DEB  = 4;
  localparam int LOCK = 8;
`ifdef HIT_LOCKOUT_EN
  localparam int LOCK_EFF = LOCK;
  localparam bit LOCK_ON  = 1'b1;
`else
  localparam int LOCK_EFF = 0;
  localparam bit LOCK_ON  = 1'b0;
`endif
  localparam int MAXT = 8192;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   n_cmp = 0, n_fail = 0;

  hit_sensor_frontend_if #(.NUM_SENSORS(NS)) bus ();

  hit_sensor_frontend #(.NUM_SENSORS(NS), .DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference model: history of synchronised/debounced levels indexed by state number.
  logic [NS-1:0] raw_h  [0:MAXT-1];
  logic [NS-1:0] sync_h [0:MAXT-1];
  logic [NS-1:0] deb_h  [0:MAXT-1];
  int            t, lock_end, exp_drop;
  bit            m_idle;
  logic          exp_hv, exp_multi;
  logic [1:0]    exp_box;

  task automatic model_reset();
    t = 0; sync_h[0] = '0; deb_h[0] = '0;
    m_idle = 1'b1; lock_end = -1; exp_drop = 0;
    exp_hv = 1'b0; exp_multi = 1'b0; exp_box = BOX_NONE;
  endtask

  task automatic model_step();
    logic [NS-1:0] d, ev;
    if (t >= MAXT - 2) begin
      n_fail++;
      $display("FAIL model_history overflow at t=%0d", t);
      $fatal(1, "model history exhausted");
    end
    raw_h[t] = bus.sensor_raw;
    t++;
    sync_h[t] = (t >= 2) ? raw_h[t-2] : '0;
    d = deb_h[t-1];
    // A level is accepted once DEB consecutive edges saw it differ from a steady deb.
    for (int c = 0; c < NS; c++) begin
      bit flip;
      flip = (t >= DEB);
      for (int k = 1; k <= DEB; k++)
        if (flip && t - k >= 0)
          if (sync_h[t-k][c] == deb_h[t-1][c] || deb_h[t-k][c] != deb_h[t-1][c]) flip = 1'b0;
      if (flip) d[c] = ~d[c];
    end
    deb_h[t] = d;
    ev = (t >= 2) ? (deb_h[t-1] & ~deb_h[t-2]) : '0;
    exp_hv = 1'b0; exp_multi = 1'b0;
    if (m_idle) begin
      if (bus.arm) m_idle = 1'b0;
    end else begin
      if (ev != '0) begin
        if (t > lock_end) begin
          exp_hv = 1'b1;
          for (int c = NS - 1; c >= 0; c--) if (ev[c]) exp_box = 2'(c);
          exp_multi = ($countones(ev) > 1);
          lock_end = t + LOCK_EFF;
        end else if (exp_drop < 255) exp_drop++;
      end
      if (!bus.arm) begin m_idle = 1'b1; lock_end = -1; end
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    bus.sensor_raw = '0; bus.arm = 1'b1; reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #3;
    n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hit_valid got %b want 0", bus.hit_valid); end
    n_cmp++; if (bus.hit_box !== 2'b11) begin n_fail++; $display("FAIL reset_hit_box got %b want 11", bus.hit_box); end
    n_cmp++; if (bus.hit_multi !== 1'b0) begin n_fail++; $display("FAIL reset_hit_multi got %b want 0", bus.hit_multi); end
    n_cmp++; if (bus.sensor_level !== 3'b000) begin n_fail++; $display("FAIL reset_level got %b want 000", bus.sensor_level); end
    n_cmp++; if (bus.dropped_count !== 8'd0) begin n_fail++; $display("FAIL reset_dropped got %0d want 0", bus.dropped_count); end
    reset = 1'b0;
    model_reset();
    repeat (5) tick();
    n_cmp++; if (bus.hit_box !== 2'b11 || bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got hv=%b box=%b want hv=0 box=11", bus.hit_valid, bus.hit_box); end
  endtask

  task automatic test_clean_strike();
    bus.sensor_raw = 3'b010;
    for (int e = 0; e <= 12; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== (e == 6)) begin n_fail++; $display("FAIL clean_hit_valid e=%0d got %b want %b", e, bus.hit_valid, (e == 6)); end
      n_cmp++; if (bus.sensor_level !== ((e >= 5) ? 3'b010 : 3'b000)) begin n_fail++; $display("FAIL clean_level e=%0d got %b", e, bus.sensor_level); end
      if (e == 6) begin
        n_cmp++; if (bus.hit_box !== 2'd1 || bus.hit_multi !== 1'b0) begin n_fail++; $display("FAIL clean_box got box=%0d multi=%b want box=1 multi=0", bus.hit_box, bus.hit_multi); end
      end
    end
    bus.sensor_raw = '0;
    repeat (12) tick();
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 3; r++) begin
      bus.sensor_raw = 3'b001;
      for (int h = 0; h < 4; h++) begin
        if (h == 3) bus.sensor_raw = 3'b000;
        tick();
        n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_spurious r=%0d h=%0d got 1 want 0", r, h); end
      end
    end
    bus.sensor_raw = 3'b001;
    for (int e = 0; e <= 10; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== (e == 6)) begin n_fail++; $display("FAIL bounce_hit_valid e=%0d got %b want %b", e, bus.hit_valid, (e == 6)); end
      if (e == 6) begin
        n_cmp++; if (bus.hit_box !== 2'd0) begin n_fail++; $display("FAIL bounce_box got %0d want 0", bus.hit_box); end
      end
    end
    bus.sensor_raw = '0;
    repeat (15) tick();
  endtask

  task automatic test_simultaneous();
    bus.sensor_raw = 3'b110;
    for (int e = 0; e <= 10; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== (e == 6)) begin n_fail++; $display("FAIL simul_hit_valid e=%0d got %b want %b", e, bus.hit_valid, (e == 6)); end
      if (e == 6) begin
        n_cmp++; if (bus.hit_box !== 2'd1 || bus.hit_multi !== 1'b1) begin n_fail++; $display("FAIL simul_box got box=%0d multi=%b want box=1 multi=1", bus.hit_box, bus.hit_multi); end
      end
    end
    bus.sensor_raw = '0;
    repeat (15) tick();
  endtask

  // Box 0 hits at H (edge 6); box 2's event lands at H+off.
  task automatic test_lockout();
    int offs [4] = '{2, 3, 8, 9};
    int drops = 0;
    for (int i = 0; i < 4; i++) begin
      bit acc;
      acc = !LOCK_ON || (offs[i] > LOCK);
      bus.sensor_raw = 3'b001;
      for (int e = 0; e <= offs[i] + 8; e++) begin
        tick();
        if (e == offs[i] - 1) bus.sensor_raw = 3'b101;
        n_cmp++; if (bus.hit_valid !== ((e == 6) || (e == offs[i] + 6 && acc))) begin n_fail++; $display("FAIL lockout_hit_valid off=%0d e=%0d got %b", offs[i], e, bus.hit_valid); end
        if (e == offs[i] + 6) begin
          n_cmp++; if (bus.hit_box !== (acc ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL lockout_box off=%0d got %0d want %0d", offs[i], bus.hit_box, acc ? 2 : 0); end
        end
      end
      if (!acc) drops++;
      n_cmp++; if (bus.dropped_count !== 8'(drops)) begin n_fail++; $display("FAIL lockout_dropped off=%0d got %0d want %0d", offs[i], bus.dropped_count, drops); end
      bus.sensor_raw = '0;
      repeat (20) tick();
    end
  endtask

  task automatic test_arming();
    bus.arm = 1'b0; bus.sensor_raw = 3'b001;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL disarmed_pulse e=%0d got 1 want 0", e); end
    end
    n_cmp++; if (bus.sensor_level !== 3'b001) begin n_fail++; $display("FAIL disarmed_level got %b want 001", bus.sensor_level); end
    bus.arm = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL held_on_arm e=%0d got 1 want 0", e); end
    end
    n_cmp++; if (bus.hit_box !== 2'd2) begin n_fail++; $display("FAIL box_hold got %0d want 2", bus.hit_box); end
    bus.sensor_raw = '0;
    repeat (10) tick();
    bus.sensor_raw = 3'b001;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== (e == 6)) begin n_fail++; $display("FAIL restrike_hit_valid e=%0d got %b want %b", e, bus.hit_valid, (e == 6)); end
      if (e == 6) begin
        n_cmp++; if (bus.hit_box !== 2'd0) begin n_fail++; $display("FAIL restrike_box got %0d want 0", bus.hit_box); end
      end
    end
    repeat (12) tick();
    bus.sensor_raw = '0;
    repeat (10) tick();
    // Disarm on the hit edge: accepted, but no lockout follows.
    bus.sensor_raw = 3'b010;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 2) bus.sensor_raw = 3'b110;
      if (e == 5) bus.arm = 1'b0;
      if (e == 6) bus.arm = 1'b1;
      n_cmp++; if (bus.hit_valid !== ((e == 6) || (e == 9))) begin n_fail++; $display("FAIL collide_hit_valid e=%0d got %b", e, bus.hit_valid); end
      if (e == 6 || e == 9) begin
        n_cmp++; if (bus.hit_box !== ((e == 6) ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL collide_box e=%0d got %0d", e, bus.hit_box); end
      end
    end
    bus.sensor_raw = '0;
    repeat (15) tick();
  endtask

  task automatic test_async_reset();
    bus.sensor_raw = 3'b001;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== (e == 6)) begin n_fail++; $display("FAIL prereset_hit_valid e=%0d got %b", e, bus.hit_valid); end
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (bus.hit_box !== 2'b11 || bus.hit_valid !== 1'b0 || bus.hit_multi !== 1'b0) begin n_fail++; $display("FAIL async_reset_hit got hv=%b box=%b multi=%b", bus.hit_valid, bus.hit_box, bus.hit_multi); end
    n_cmp++; if (bus.sensor_level !== 3'b000) begin n_fail++; $display("FAIL async_reset_level got %b want 000", bus.sensor_level); end
    n_cmp++; if (bus.dropped_count !== 8'd0) begin n_fail++; $display("FAIL async_reset_dropped got %0d want 0", bus.dropped_count); end
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #3 reset = 1'b0;
    model_reset();
    for (int e = 0; e <= 10; e++) begin
      tick();
      n_cmp++; if (bus.hit_valid !== (e == 6)) begin n_fail++; $display("FAIL post_reset_hit_valid e=%0d got %b want %b", e, bus.hit_valid, (e == 6)); end
      n_cmp++; if (bus.sensor_level !== ((e >= 5) ? 3'b001 : 3'b000)) begin n_fail++; $display("FAIL post_reset_level e=%0d got %b", e, bus.sensor_level); end
    end
    bus.sensor_raw = '0;
    repeat (15) tick();
  endtask

  task automatic test_random();
    int hold [NS];
    for (int c = 0; c < NS; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < NS; c++) begin
        if (hold[c] == 0) begin
          bus.sensor_raw[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
        end else hold[c]--;
      end
      if (bus.arm) begin
        if ($urandom_range(0, 79) == 0) bus.arm = 1'b0;
      end else if ($urandom_range(0, 5) == 0) bus.arm = 1'b1;
      tick();
      n_cmp++; if (bus.hit_valid !== exp_hv) begin n_fail++; $display("FAIL rand_hit_valid cyc=%0d got %b want %b", cyc, bus.hit_valid, exp_hv); end
      n_cmp++; if (bus.hit_box !== exp_box) begin n_fail++; $display("FAIL rand_hit_box cyc=%0d got %0d want %0d", cyc, bus.hit_box, exp_box); end
      n_cmp++; if (bus.hit_multi !== exp_multi) begin n_fail++; $display("FAIL rand_hit_multi cyc=%0d got %b want %b", cyc, bus.hit_multi, exp_multi); end
      n_cmp++; if (bus.sensor_level !== deb_h[t]) begin n_fail++; $display("FAIL rand_level cyc=%0d got %b want %b", cyc, bus.sensor_level, deb_h[t]); end
      n_cmp++; if (bus.dropped_count !== 8'(exp_drop)) begin n_fail++; $display("FAIL rand_dropped cyc=%0d got %0d want %0d", cyc, bus.dropped_count, exp_drop); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_strike();
    test_bounce();
    test_simultaneous();
    test_lockout();
    test_arming();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_sensor_frontend.md
# hit_sensor_frontend

Conditions the raw whack-sensor lines from GPIO_1 into clean, single-cycle hit events for the game datapath. Each channel is synchronised, debounced and rising-edge detected. Accepted hits are arbitrated to one box index, and a post-hit lockout window suppresses piezo ringing and double strikes. The block sits directly upstream of the datapath and supplies its `box_address` and `hit_detected` inputs.

## Interface
Parameters:
- `NUM_SENSORS`, default 3: number of sensor channels. Supported range is 1..3, since box codes 0..2 are valid and 3 means "none".
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Must be ≥ 1.
- `LOCKOUT_CYCLES`, default 5000000: length of the post-hit ignore window (100 ms). Must be ≥ 1.

Ports:
- `CLOCK_50`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high.
- `sensor_raw`, input, NUM_SENSORS: asynchronous sensor lines; bit i is box i; 1 means struck.
- `arm`, input, 1: game active; hits are only accepted while high.
- `hit_valid`, output, 1: one-cycle pulse per accepted hit.
- `hit_box`, output, 2: box index of the last accepted hit; 2'b11 means none.
- `hit_multi`, output, 1: high with `hit_valid` when more than one channel produced an event in the same cycle.
- `sensor_level`, output, NUM_SENSORS: debounced levels, for LED mirroring.
- `dropped_count`, output, 8: saturating count of events discarded during lockout.

## Operation
- Per channel:
  - 2-FF synchroniser produces `sync`.
  - Debounce counter: on each edge where `sync` != `deb`, increment. When the count would reach DEBOUNCE_CYCLES, set `deb <= sync` and clear the count.
  - Any edge where `sync` == `deb` clears the count, so bounce shorter than DEBOUNCE_CYCLES is rejected.
  - `deb_q` is `deb` delayed one cycle.
  - `event[i] = deb & ~deb_q`. Only rising edges count; falling edges are never events.
- FSM states: IDLE, ARMED, LOCKOUT.
  - IDLE: events ignored and not counted. Go to ARMED when `arm`=1.
  - ARMED: if any event, then on the next edge pulse `hit_valid`, set `hit_box` to the lowest-index active event, set `hit_multi` to (popcount > 1), load the lockout counter, and go to LOCKOUT.
  - LOCKOUT: events are dropped. Each dropped cycle increments `dropped_count` once (saturates at 255). Return to ARMED after LOCKOUT_CYCLES cycles.
  - `arm`=0 in any state: go to IDLE on the next edge and clear the lockout counter. `hit_box`, `dropped_count` and `sensor_level` keep their values.
- A sensor already held high when `arm` rises does not fire; it must release and restrike.
- `hit_box` holds its value between hits.

## Timing
- Reset values:
  - `hit_valid`=0, `hit_box`=2'b11, `hit_multi`=0, `sensor_level`=0, `dropped_count`=0.
  - FSM in IDLE; all counters and synchronisers 0.
- Latency, with edge 0 as the first edge that samples the new raw level:
  - `sensor_level` updates at edge DEBOUNCE_CYCLES+1.
  - `hit_valid` is high for the cycle following edge DEBOUNCE_CYCLES+2.
- Lockout: with `hit_valid` registered at edge H, events at edges H+1 .. H+LOCKOUT_CYCLES are dropped. An event at edge H+LOCKOUT_CYCLES+1 is accepted.
- Minimum hit spacing is LOCKOUT_CYCLES+1 cycles. `hit_valid` never stays high for two consecutive cycles.
- Arm/event collision: if `arm` falls on the same edge as an event in ARMED, the hit is still accepted and the FSM goes to IDLE, not LOCKOUT.
- Reset asserted mid-debounce or mid-lockout clears everything immediately and asynchronously. The first hit after reset needs full debounce.

## Configuration
- `HIT_LOCKOUT_EN` defined: behaviour as above.
- `HIT_LOCKOUT_EN` not defined:
  - LOCKOUT state and its counter are not built.
  - ARMED accepts an event on every cycle, so hits may be spaced 1 cycle apart, limited only by debounce.
  - `dropped_count` is tied to 0.

## Structure
- Package `hit_pkg`:
  - `BOX_NONE` = 2'b11.
  - FSM state enum `hit_state_t` (IDLE, ARMED, LOCKOUT).
  - Default constants for DEBOUNCE_CYCLES and LOCKOUT_CYCLES at 50 MHz.
- Sub-module `sensor_debounce`: one instance per channel, containing the synchroniser, debounce counter and `deb`/`deb_q`. It outputs `level` and `rise`.
- Top level: arbitration, FSM, lockout counter and drop counter.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, `arm`=1 unless stated.
- Clean strike: raise `sensor_raw[1]` and hold → exactly one `hit_valid` pulse, at edge 6; `hit_box`=1, `hit_multi`=0; `sensor_level`=3'b010 from edge 5.
- Bounce: toggle `sensor_raw[0]` with a 3-cycle high, 1-cycle low pattern, then hold high → no pulse during the toggling; one pulse 6 edges after the final rise, with `hit_box`=0.
- Simultaneous: raise `sensor_raw[2]` and `sensor_raw[1]` on the same edge → one pulse with `hit_box`=1 and `hit_multi`=1.
- Lockout: strike box 0, then strike box 2 so its event lands at H+3 → no second pulse and `dropped_count`=1. Strike box 2 again with its event at H+9 → accepted, `hit_box`=2.
- Arming: hold `sensor_raw[0]` high with `arm`=0, then raise `arm` → no pulse. Release, then restrike → pulse. Apply async `reset` mid-lockout → all outputs return to reset values at once.
- Macro off (`HIT_LOCKOUT_EN` undefined): two boxes' events 2 cycles apart → two pulses, and `dropped_count` stays 0.
